// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: valid/ready pipeline latch between two stages.
// Carries a control field and a data field. With SKID=1 a second entry
// catches one extra instruction so in_ready can be registered. With SKID=0
// the stage is a single register with combinational in_ready.
// Flush empties the stage synchronously. Control is forced to zero whenever
// the main entry is empty, so Execute sees a NOP bubble.
module id_ex_pipe_reg #(
  parameter int CTRL_W = 14,
  parameter int DATA_W = 138,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam bit USE_SKID = (SKID != 0);

  // Main entry (drives out_*) and skid entry.
  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;

  logic accept_s;
  logic consume_s;
  logic m_free_s;

  assign accept_s  = in_valid & in_ready;
  assign consume_s = m_valid_q & out_ready;
  // The main entry can take new content this edge.
  assign m_free_s  = ~m_valid_q | consume_s;

  // Next-state for both entries: flush first, then refill M from S or input.
  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_valid_d = 1'b0;
    end else if (m_free_s) begin
      if (USE_SKID && s_valid_q) begin
        // Skid entry moves up; in_ready is low so nothing is accepted.
        m_valid_d = 1'b1;
        m_ctrl_d  = s_ctrl_q;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (accept_s) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = in_ctrl;
        m_data_d  = in_data;
      end else begin
        // Drained with nothing behind it: present a bubble, keep old data.
        m_valid_d = 1'b0;
        m_ctrl_d  = '0;
      end
    end else begin
      // M is stalled; an accepted instruction lands in the skid entry.
      if (USE_SKID && accept_s) begin
        s_valid_d = 1'b1;
        s_ctrl_d  = in_ctrl;
        s_data_d  = in_data;
      end else begin
        s_valid_d = s_valid_q;
      end
    end
    if (!USE_SKID) begin
      s_valid_d = 1'b0;
    end else begin
      s_valid_d = s_valid_d;
    end
  end

  // Entry registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_ctrl_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_ctrl_q  <= m_ctrl_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_ctrl_q  <= s_ctrl_d;
      s_data_q  <= s_data_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid_ready
      logic in_ready_q;
      logic in_ready_d;

      assign in_ready_d = ~s_valid_d;

      // Registered ready: high whenever the skid entry will be empty.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          in_ready_q <= 1'b0;
        end else begin
          in_ready_q <= in_ready_d;
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_comb_ready
      assign in_ready = ~m_valid_q | out_ready;
    end
  endgenerate

  assign out_valid = m_valid_q;
  assign out_ctrl  = m_ctrl_q;
  assign out_data  = m_data_q;
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

endmodule
